// File: rtl/bnn_pkg.sv
// Shared constants and types for the binary CNN datapath blocks.
package bnn_pkg;

  localparam int NMAX = 28;
  localparam int N_L1 = 28;
  localparam int N_L2 = 12;
  localparam int K    = 3;

  localparam logic LAYER_L1 = 1'b0;
  localparam logic LAYER_L2 = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} win_state_e;

  function automatic logic [4:0] layer_ni(input logic sel);
    return (sel == LAYER_L2) ? 5'(N_L2) : 5'(N_L1);
  endfunction

endpackage

// File: rtl/line_fifo.sv
// One feature-map line of delay: 1-bit shift register with a runtime read tap,
// so the same storage serves any line length up to NMAX.
module line_fifo #(
  parameter int NMAX = 28
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       shift_i,
  input  logic       din_i,
  input  logic [4:0] idx_i,
  output logic       dout_o
);

  logic [NMAX-1:0] sr_q;
  logic [NMAX-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_i) sr_d = {sr_q[NMAX-2:0], din_i};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  // Reading index Ni-1 before the shift yields the pixel exactly one line back.
  assign dout_o = sr_q[idx_i];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order 1-bit pixel stream in, one registered 3-row column per accepted pixel out.
// Frame FSM, row/column counters and output registers; line buffers live in line_fifo.
module conv_window_gen #(
  parameter int K    = 3,
  parameter int NMAX = 28
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         state,
  input  logic         din,
  input  logic         din_valid,
  output logic [K-1:0] taps,
  output logic         tvalid,
  output logic         win_valid,
  output logic         busy,
  output logic         frame_done
);

  import bnn_pkg::*;

  win_state_e   fsm_q, fsm_d;
  logic [4:0]   ni_q, ni_d;
  logic [4:0]   row_q, row_d;
  logic [4:0]   col_q, col_d;
  logic [K-1:0] taps_q, taps_d;
  logic         tvalid_q, tvalid_d;
  logic         win_q, win_d;
  logic         accept;
  logic         lb1_out, lb2_out;
  logic [4:0]   last_idx;

  assign last_idx = ni_q - 5'd1;

  always_comb begin
    fsm_d    = fsm_q;
    ni_d     = ni_q;
    row_d    = row_q;
    col_d    = col_q;
    taps_d   = taps_q;
    tvalid_d = 1'b0;
    win_d    = 1'b0;
    accept   = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d = RUN;
          ni_d  = layer_ni(state);
          row_d = 5'd0;
          col_d = 5'd0;
        end
      end
      RUN: begin
        if (din_valid) begin
          accept   = 1'b1;
          taps_d   = {lb2_out, lb1_out, din};
          // Rows 0 and 1 would expose the previous frame's lines.
          tvalid_d = (row_q >= 5'd2);
          win_d    = (row_q >= 5'd2) && (col_q >= 5'd2);
          if (col_q == last_idx) begin
            col_d = 5'd0;
            row_d = row_q + 5'd1;
            if (row_q == last_idx) fsm_d = DONE;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q    <= IDLE;
      ni_q     <= 5'd0;
      row_q    <= 5'd0;
      col_q    <= 5'd0;
      taps_q   <= '0;
      tvalid_q <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      ni_q     <= ni_d;
      row_q    <= row_d;
      col_q    <= col_d;
      taps_q   <= taps_d;
      tvalid_q <= tvalid_d;
      win_q    <= win_d;
    end
  end

  line_fifo #(.NMAX(NMAX)) u_lb1 (
    .clk     (clk),
    .rstn    (rstn),
    .shift_i (accept),
    .din_i   (din),
    .idx_i   (last_idx),
    .dout_o  (lb1_out)
  );

  line_fifo #(.NMAX(NMAX)) u_lb2 (
    .clk     (clk),
    .rstn    (rstn),
    .shift_i (accept),
    .din_i   (lb1_out),
    .idx_i   (last_idx),
    .dout_o  (lb2_out)
  );

  assign taps       = taps_q;
  assign tvalid     = tvalid_q;
  assign win_valid  = win_q;
  assign busy       = (fsm_q != IDLE);
  assign frame_done = (fsm_q == DONE);

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: frame patterns, bubbles, ignored controls,
// mid-frame reset and back-to-back frames against a pixel-formula model.
module tb_conv_window_gen;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       state;
  logic       din;
  logic       din_valid;
  logic [2:0] taps;
  logic       tvalid;
  logic       win_valid;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  conv_window_gen #(.K(3), .NMAX(28)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .state      (state),
    .din        (din),
    .din_valid  (din_valid),
    .taps       (taps),
    .tvalid     (tvalid),
    .win_valid  (win_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial forever #5 clk = ~clk;

  // Observation state
  int         cyc = 0;
  bit         acc_prev = 1'b0;
  int         n_acc, n_tv, n_win, n_done, stray, max_gap;
  int         first_acc, last_acc, first_tv, done_cyc;
  logic [2:0] q_taps[$];
  bit         q_win[$];
  logic [2:0] exp_taps_q[$];
  bit         exp_win_q[$];
  logic [2:0] saved_q[$];
  bit         tmo;

  always @(posedge clk) begin
    if (din_valid === 1'b1 && busy === 1'b1 && rstn === 1'b1) begin
      if (n_acc == 0) first_acc = cyc;
      else if (cyc - last_acc > max_gap) max_gap = cyc - last_acc;
      last_acc = cyc;
      n_acc++;
      acc_prev = 1'b1;
    end else begin
      acc_prev = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (tvalid === 1'b1) begin
      if (n_tv == 0) first_tv = cyc;
      n_tv++;
      q_taps.push_back(taps);
      q_win.push_back(win_valid);
      if (win_valid === 1'b1) n_win++;
      if (!acc_prev) stray++;
    end else if (win_valid === 1'b1) begin
      stray++;
    end
    if (frame_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  function automatic logic pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 1'b1;
      1:       return 1'(((r + c) & 1));
      default: return (((r * r + 3 * c + r * c) % 5) < 2);
    endcase
  endfunction

  task automatic clear_mon();
    n_acc = 0; n_tv = 0; n_win = 0; n_done = 0; stray = 0; max_gap = 0;
    first_acc = -1; last_acc = -1; first_tv = -1; done_cyc = -1;
    q_taps.delete(); q_win.delete(); exp_taps_q.delete(); exp_win_q.delete();
    tmo = 1'b0;
  endtask

  task automatic build_exp(input int pat, input int ni);
    for (int r = 2; r < ni; r++)
      for (int c = 0; c < ni; c++) begin
        exp_taps_q.push_back({pix(pat, r - 2, c), pix(pat, r - 1, c), pix(pat, r, c)});
        exp_win_q.push_back(c >= 2);
      end
  endtask

  // Drives one frame; poke_at injects start/state changes, abort_at asserts reset.
  task automatic drive_frame(input logic sel, input int pat, input bit bubbles,
                             input int poke_at, input int abort_at, input bit wait_idle);
    int ni;
    int n;
    ni = sel ? 12 : 28;
    @(posedge clk); #1;
    start = 1'b1; state = sel;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < ni * ni; i++) begin
      if (i == abort_at) begin
        din_valid = 1'b0;
        rstn = 1'b0;
        return;
      end
      if (bubbles)
        for (int b = 0; b < 3 && $urandom_range(0, 1) == 1; b++) begin
          din_valid = 1'b0;
          din = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      din       = pix(pat, i / ni, i % ni);
      din_valid = 1'b1;
      start     = (i == poke_at);
      state     = (poke_at >= 0 && i >= poke_at) ? ~sel : sel;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    start     = 1'b0;
    if (wait_idle) begin
      n = 0;
      while (busy !== 1'b0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (busy !== 1'b0) tmo = 1'b1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; state = 1'b0; din = 1'b0; din_valid = 1'b0;
    clear_mon();
    #3;
    total++; if (taps !== 3'b000) begin bad++; $display("FAIL reset_taps got=%b want=000", taps); end
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", tvalid); end
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_win got=%b want=0", win_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    din = 1'b1; din_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 din_valid = 1'b0;
    @(negedge clk);
    total++;
    if (n_tv !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_din_ignored tvalids=%0d busy=%b want 0/0", n_tv, busy);
    end
  endtask

  task automatic test_allones_l2();
    clear_mon();
    drive_frame(1'b1, 0, 1'b0, -1, -1, 1'b1);
    total++; if (tmo) begin bad++; $display("FAIL ones_timeout busy stuck"); end
    total++; if (n_tv !== 120) begin bad++; $display("FAIL ones_tvalid_count got=%0d want=120", n_tv); end
    total++; if (n_win !== 100) begin bad++; $display("FAIL ones_win_count got=%0d want=100", n_win); end
    total++;
    if (first_tv - first_acc !== 25) begin
      bad++; $display("FAIL ones_first_tvalid_latency got=%0d want=25", first_tv - first_acc);
    end
    total++;
    if (done_cyc - last_acc !== 1) begin
      bad++; $display("FAIL ones_done_timing got=%0d want=1", done_cyc - last_acc);
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL ones_done_count got=%0d want=1", n_done); end
    for (int k = 0; k < q_taps.size(); k++) begin
      total++;
      if (q_taps[k] !== 3'b111) begin
        bad++; $display("FAIL ones_taps idx=%0d got=%b want=111", k, q_taps[k]);
      end
    end
  endtask

  task automatic test_checker_l1();
    clear_mon();
    drive_frame(1'b0, 1, 1'b0, -1, -1, 1'b1);
    build_exp(1, 28);
    total++; if (tmo) begin bad++; $display("FAIL chk_timeout busy stuck"); end
    total++; if (n_tv !== 728) begin bad++; $display("FAIL chk_tvalid_count got=%0d want=728", n_tv); end
    total++; if (n_win !== 676) begin bad++; $display("FAIL chk_win_count got=%0d want=676", n_win); end
    for (int k = 0; k < exp_taps_q.size(); k++) begin
      total++;
      if (k >= q_taps.size() || q_taps[k] !== exp_taps_q[k] || q_win[k] !== exp_win_q[k]) begin
        bad++;
        $display("FAIL chk_column idx=%0d got=%b/%b want=%b/%b", k,
                 (k < q_taps.size()) ? q_taps[k] : 3'bxxx, (k < q_win.size()) ? q_win[k] : 1'b0,
                 exp_taps_q[k], exp_win_q[k]);
      end
    end
  endtask

  task automatic test_bubbles_l2();
    clear_mon();
    drive_frame(1'b1, 2, 1'b0, -1, -1, 1'b1);
    build_exp(2, 12);
    saved_q = q_taps;
    for (int k = 0; k < exp_taps_q.size(); k++) begin
      total++;
      if (k >= q_taps.size() || q_taps[k] !== exp_taps_q[k]) begin
        bad++; $display("FAIL gapless_taps idx=%0d want=%b", k, exp_taps_q[k]);
      end
    end
    clear_mon();
    drive_frame(1'b1, 2, 1'b1, -1, -1, 1'b1);
    total++; if (tmo) begin bad++; $display("FAIL bub_timeout busy stuck"); end
    total++; if (n_tv !== 120) begin bad++; $display("FAIL bub_tvalid_count got=%0d want=120", n_tv); end
    total++; if (stray !== 0) begin bad++; $display("FAIL bub_stray_tvalid got=%0d want=0", stray); end
    for (int k = 0; k < saved_q.size(); k++) begin
      total++;
      if (k >= q_taps.size() || q_taps[k] !== saved_q[k]) begin
        bad++; $display("FAIL bub_taps idx=%0d want=%b", k, saved_q[k]);
      end
    end
  endtask

  task automatic test_ignore_ctrl();
    clear_mon();
    drive_frame(1'b1, 2, 1'b0, 40, -1, 1'b1);
    build_exp(2, 12);
    total++; if (tmo) begin bad++; $display("FAIL ign_timeout busy stuck"); end
    total++; if (n_tv !== 120) begin bad++; $display("FAIL ign_tvalid_count got=%0d want=120", n_tv); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", n_done); end
    for (int k = 0; k < exp_taps_q.size(); k++) begin
      total++;
      if (k >= q_taps.size() || q_taps[k] !== exp_taps_q[k]) begin
        bad++; $display("FAIL ign_taps idx=%0d want=%b", k, exp_taps_q[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    drive_frame(1'b0, 2, 1'b0, -1, 60, 1'b0);
    @(negedge clk);
    total++;
    if ({taps, tvalid, win_valid, busy, frame_done} !== 7'b0) begin
      bad++; $display("FAIL midrst_outputs got=%b want=0000000", {taps, tvalid, win_valid, busy, frame_done});
    end
    @(posedge clk); #1 rstn = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (n_done !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", n_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    clear_mon();
    drive_frame(1'b1, 2, 1'b0, -1, -1, 1'b1);
    build_exp(2, 12);
    total++; if (n_tv !== 120) begin bad++; $display("FAIL midrst_next_count got=%0d want=120", n_tv); end
    for (int k = 0; k < exp_taps_q.size(); k++) begin
      total++;
      if (k >= q_taps.size() || q_taps[k] !== exp_taps_q[k]) begin
        bad++; $display("FAIL midrst_next_taps idx=%0d want=%b", k, exp_taps_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    drive_frame(1'b0, 1, 1'b0, -1, -1, 1'b0);
    drive_frame(1'b1, 2, 1'b0, -1, -1, 1'b1);
    build_exp(1, 28);
    build_exp(2, 12);
    total++; if (tmo) begin bad++; $display("FAIL b2b_timeout busy stuck"); end
    total++; if (n_tv !== 848) begin bad++; $display("FAIL b2b_tvalid_count got=%0d want=848", n_tv); end
    total++; if (n_win !== 776) begin bad++; $display("FAIL b2b_win_count got=%0d want=776", n_win); end
    total++; if (n_done !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", n_done); end
    total++; if (max_gap !== 3) begin bad++; $display("FAIL b2b_frame_gap got=%0d want=3", max_gap); end
    for (int k = 0; k < exp_taps_q.size(); k++) begin
      total++;
      if (k >= q_taps.size() || q_taps[k] !== exp_taps_q[k] || q_win[k] !== exp_win_q[k]) begin
        bad++; $display("FAIL b2b_column idx=%0d want=%b/%b", k, exp_taps_q[k], exp_win_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_allones_l2();
    test_checker_l1();
    test_bubbles_l2();
    test_ignore_ctrl();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
